// File: rtl/child_bit_serializer.sv
// -----------------------------------------------------------------------------
// child_bit_serializer
//
// Parallel-to-serial transmitter feeding the single-bit `b` input of `child`.
// One word is accepted per valid/ready handshake and shifted out LSB first as
// a framed stream: start bit (0), WIDTH+1 data bits, optional even-parity bit,
// stop bit (1). Every serial bit is held for CLKS_PER_BIT clock cycles.
//
// Configuration macro:
//   CHILD_SER_PARITY_EN  defined   -> PARITY state present, frame is WIDTH+4 bits
//                        undefined -> no parity logic, frame is WIDTH+3 bits
//
// Parameters:
//   WIDTH         MSB index of the data word (word is WIDTH+1 bits, 1..31)
//   CLKS_PER_BIT  clock cycles per serial bit (1..65535)
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   a_valid  in   upstream word valid
//   a_ready  out  block can accept a word this cycle (IDLE only)
//   a        in   parallel data word, captured on handshake
//   b        out  serial line, idles high
//   busy     out  frame in progress
//   done     out  one-cycle pulse on the last cycle of the stop bit
//
// All outputs are registered; none depends combinationally on an input.
// -----------------------------------------------------------------------------
module child_bit_serializer #(
  parameter int WIDTH        = 7,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [WIDTH:0] a,
  output logic           b,
  output logic           busy,
  output logic           done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);

`ifdef CHILD_SER_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH:0] shift_q, shift_d;
`ifdef CHILD_SER_PARITY_EN
  logic           parity_q, parity_d;
`endif

  logic b_q, b_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic a_ready_q, a_ready_d;

  logic bit_end;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef CHILD_SER_PARITY_EN
    parity_d  = parity_q;
`endif

    bit_end = (clk_cnt_q == LAST_CLK);

    // The bit-period counter runs in every non-idle state and reloads to 0
    // whenever the current bit (and therefore possibly the state) ends.
    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // a_ready_q is the handshake qualifier so acceptance matches exactly
        // what upstream observes on the a_ready port.
        if (a_valid && a_ready_q) begin
          state_d   = S_START;
          shift_d   = a;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
`ifdef CHILD_SER_PARITY_EN
          parity_d  = ^a;
`endif
        end
      end

      S_START: begin
        if (bit_end) state_d = S_DATA;
      end

      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          // Compare against WIDTH rather than relying on wrap, so non-power-of-2
          // word sizes leave DATA after exactly WIDTH+1 bits.
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef CHILD_SER_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

`ifdef CHILD_SER_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif

      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the *next* state and registered, so the port
    // values line up with the state the FSM is in during the same cycle.
    a_ready_d = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_STOP) && (clk_cnt_d == LAST_CLK);

    unique case (state_d)
      S_START:  b_d = 1'b0;
      S_DATA:   b_d = shift_d[0];
`ifdef CHILD_SER_PARITY_EN
      S_PARITY: b_d = parity_d;
`endif
      default:  b_d = 1'b1;  // IDLE and STOP hold the line high
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values, independent of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef CHILD_SER_PARITY_EN
      parity_q  <= 1'b0;
`endif
      b_q       <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
`ifdef CHILD_SER_PARITY_EN
      parity_q  <= parity_d;
`endif
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      a_ready_q <= a_ready_d;
    end
  end

  assign a_ready = a_ready_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_child_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_child_bit_serializer
//
// Directed self-checking bench for child_bit_serializer. Two instances:
//   u_dut1  WIDTH=7, CLKS_PER_BIT=1  (reset, single frame, back-to-back,
//                                     reset mid-frame / on handshake, stall)
//   u_dut2  WIDTH=7, CLKS_PER_BIT=2  (bit stretching, parity when
//                                     CHILD_SER_PARITY_EN is defined)
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_child_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, a2_valid;
  logic [7:0] a, a2;
  logic       a_ready, b, busy, done;
  logic       a2_ready, b2, busy2, done2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  child_bit_serializer #(.WIDTH(7), .CLKS_PER_BIT(1)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done)
  );

  child_bit_serializer #(.WIDTH(7), .CLKS_PER_BIT(2)) u_dut2 (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a2_valid),
    .a_ready (a2_ready),
    .a       (a2),
    .b       (b2),
    .busy    (busy2),
    .done    (done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one word into u_dut1 (a_ready must already be high).
  task automatic send1(input logic [7:0] w);
    a       = w;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
  endtask

  // Check n cycles of a CLKS_PER_BIT=1 frame, starting at the start-bit cycle.
  // With scramble set, `a` keeps changing while a_valid stays high.
  task automatic check_frame1(input string tag, input logic [7:0] w, input int n,
                              input bit scramble);
    logic [9:0] exp_bits;
    exp_bits = {1'b1, w, 1'b0};
    for (int i = 0; i < n; i++) begin
      check({tag, "_b"},     b,       exp_bits[i]);
      check({tag, "_busy"},  busy,    1'b1);
      check({tag, "_done"},  done,    (i == 9));
      check({tag, "_ready"}, a_ready, 1'b0);
      if (scramble) a = a + 8'h1D;
      tick();
    end
  endtask

  task automatic check_idle1(input string tag);
    check({tag, "_b"},     b,       1'b1);
    check({tag, "_busy"},  busy,    1'b0);
    check({tag, "_done"},  done,    1'b0);
    check({tag, "_ready"}, a_ready, 1'b1);
  endtask

  // Send and check a CLKS_PER_BIT=2 frame on u_dut2; par is the hand-computed
  // even-parity bit (only transmitted when the parity build is selected).
  task automatic frame2(input string tag, input logic [7:0] w, input logic par);
    logic [10:0] bits;
    int          nb;
    int          busy_cycles;
`ifdef CHILD_SER_PARITY_EN
    bits = {1'b1, par, w, 1'b0};
    nb   = 11;
`else
    bits = {1'b0, 1'b1, w, 1'b0};
    nb   = 10;
    if (par) bits[10] = 1'b0;  // parity unused without the parity build
`endif
    busy_cycles = 0;
    a2       = w;
    a2_valid = 1'b1;
    tick();
    a2_valid = 1'b0;
    for (int i = 0; i < 2 * nb; i++) begin
      check({tag, "_b"},    b2,    bits[i/2]);
      check({tag, "_done"}, done2, (i == 2 * nb - 1));
      if (busy2) busy_cycles++;
      tick();
    end
`ifdef CHILD_SER_PARITY_EN
    check({tag, "_busy_len"}, busy_cycles, 22);
`else
    check({tag, "_busy_len"}, busy_cycles, 20);
`endif
    check({tag, "_end_busy"},  busy2,    1'b0);
    check({tag, "_end_ready"}, a2_ready, 1'b1);
    check({tag, "_end_b"},     b2,       1'b1);
  endtask

  initial begin
    reset    = 1'b1;
    a_valid  = 1'b1;
    a        = 8'h55;
    a2_valid = 1'b0;
    a2       = 8'h00;

    // ---- Reset held 3 cycles with a_valid high ------------------------------
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_b",     b,       1'b1);
      check("rst_ready", a_ready, 1'b0);
      check("rst_busy",  busy,    1'b0);
      check("rst_done",  done,    1'b0);
    end
    reset   = 1'b0;
    a_valid = 1'b0;
    tick();
    check("rel_ready",  a_ready,  1'b1);
    check("rel_busy",   busy,     1'b0);
    check("rel_ready2", a2_ready, 1'b1);

    // ---- Single frame 8'hA5: b = 0,1,0,1,0,0,1,0,1,1 ------------------------
    send1(8'hA5);
    check_frame1("a5", 8'hA5, 10, 1'b0);
    check_idle1("a5_end");

    // ---- Back-to-back 8'hFF then 8'h00, a_valid held high --------------------
    a       = 8'hFF;
    a_valid = 1'b1;
    tick();
    a = 8'h00;  // must not be captured before the first frame completes
    check_frame1("b2b_ff", 8'hFF, 10, 1'b0);
    check_idle1("b2b_gap");
    tick();
    a_valid = 1'b0;
    check_frame1("b2b_00", 8'h00, 10, 1'b0);
    check_idle1("b2b_end");

    // ---- Reset during data bit 3 of 8'hC3 ------------------------------------
    send1(8'hC3);
    check_frame1("mid", 8'hC3, 4, 1'b0);
    check("mid_bit3", b, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst_b",    b,    1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_post_done", done, 1'b0);
      check("mid_post_b",    b,    1'b1);
    end
    check_idle1("mid_idle");
    send1(8'h3C);
    check_frame1("x3c", 8'h3C, 10, 1'b0);
    check_idle1("x3c_end");

    // ---- Reset coincident with a handshake: no capture -----------------------
    a       = 8'h81;
    a_valid = 1'b1;
    reset   = 1'b1;
    tick();
    check("rh_busy", busy, 1'b0);
    check("rh_b",    b,    1'b1);
    reset   = 1'b0;
    a_valid = 1'b0;
    tick();
    check("rh_busy2", busy,    1'b0);
    check("rh_ready", a_ready, 1'b1);

    // ---- Stall: a_valid high with changing a during a frame -----------------
    a       = 8'h96;
    a_valid = 1'b1;
    tick();
    check_frame1("stall_96", 8'h96, 10, 1'b1);
    check_idle1("stall_gap");
    a = 8'h5A;  // value present at the next handshake edge
    tick();
    a_valid = 1'b0;
    check_frame1("stall_5a", 8'h5A, 10, 1'b0);
    check_idle1("stall_end");

    // ---- CLKS_PER_BIT=2 frames (parity 0 for A5, 1 for 07) -------------------
    frame2("c2_a5", 8'hA5, 1'b0);
    tick();
    frame2("c2_07", 8'h07, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
